// File: rtl/ibuffer_scoreboard_if.sv
// Instruction-buffer, issue and writeback-release signals of the issue-stage scoreboard.
// The slave modport is the scoreboard's view; the master modport is the surrounding pipeline's view.
interface ibuffer_scoreboard_if #(
    parameter int ISSUE_WARPS = 4,
    parameter int NR_BITS     = 6,
    parameter int DATAW       = 64
);
    localparam int WIS_W = (ISSUE_WARPS > 1) ? $clog2(ISSUE_WARPS) : 1;

    logic               ibuf_valid;
    logic               ibuf_ready;
    logic [WIS_W-1:0]   ibuf_wis;
    logic               ibuf_wb;
    logic [NR_BITS-1:0] ibuf_rd;
    logic [NR_BITS-1:0] ibuf_rs1;
    logic [NR_BITS-1:0] ibuf_rs2;
    logic [NR_BITS-1:0] ibuf_rs3;
    logic [DATAW-1:0]   ibuf_data;

    logic               out_valid;
    logic               out_ready;
    logic [WIS_W-1:0]   out_wis;
    logic [DATAW-1:0]   out_data;

    logic               wb_valid;
    logic [WIS_W-1:0]   wb_wis;
    logic [NR_BITS-1:0] wb_rd;
    logic               wb_eop;

    modport slave (
        input  ibuf_valid, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_data,
        output ibuf_ready,
        output out_valid, out_wis, out_data,
        input  out_ready,
        input  wb_valid, wb_wis, wb_rd, wb_eop
    );

    modport master (
        output ibuf_valid, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_data,
        input  ibuf_ready,
        input  out_valid, out_wis, out_data,
        output out_ready,
        output wb_valid, wb_wis, wb_rd, wb_eop
    );
endinterface

// File: rtl/ibuffer_scoreboard.sv
// Single-entry issue buffer with a per-warp register scoreboard: holds one instruction until
// none of its source (or, for writers, destination) registers has an outstanding writeback.
module ibuffer_scoreboard #(
    parameter int ISSUE_WARPS = 4,
    parameter int NR_BITS     = 6,
    parameter int DATAW       = 64,
    parameter int PERF_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    ibuffer_scoreboard_if.slave bus,
    output logic [PERF_W-1:0]   perf_stalls,
    output logic                busy
);
    localparam int WIS_W = (ISSUE_WARPS > 1) ? $clog2(ISSUE_WARPS) : 1;
    localparam int NREGS = 1 << NR_BITS;

    typedef logic [ISSUE_WARPS-1:0][NREGS-1:0] pend_t;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_STALL = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic logic hazard_f(input pend_t pend, input logic [WIS_W-1:0] wis,
                                      input logic wb, input logic [NR_BITS-1:0] rd,
                                      input logic [NR_BITS-1:0] rs1, input logic [NR_BITS-1:0] rs2,
                                      input logic [NR_BITS-1:0] rs3);
        return pend[wis][rs1] | pend[wis][rs2] | pend[wis][rs3] | (wb & pend[wis][rd]);
    endfunction

    state_t             state_q, state_d;
    pend_t              pending_q, pending_d;
    logic [WIS_W-1:0]   wis_q, wis_d;
    logic               wb_q, wb_d;
    logic [NR_BITS-1:0] rd_q, rd_d;
    logic [NR_BITS-1:0] rs1_q, rs1_d;
    logic [NR_BITS-1:0] rs2_q, rs2_d;
    logic [NR_BITS-1:0] rs3_q, rs3_d;
    logic [DATAW-1:0]   data_q, data_d;
    logic [PERF_W-1:0]  perf_q, perf_d;

    logic out_valid_c;
    logic out_fire;
    logic ibuf_ready_c;
    logic in_fire;
    logic held_d;

    // STALL/READY is resolved against next cycle's bitmap, so out_valid is a pure register decode.
    assign out_valid_c  = (state_q == ST_READY);
    assign out_fire     = out_valid_c & bus.out_ready;
    assign ibuf_ready_c = reset_n & ((state_q == ST_EMPTY) | out_fire);
    assign in_fire      = bus.ibuf_valid & ibuf_ready_c;

    assign bus.ibuf_ready = ibuf_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_wis    = wis_q;
    assign bus.out_data   = data_q;
    assign perf_stalls    = perf_q;
    assign busy           = (|pending_q) | (state_q != ST_EMPTY);

    always_comb begin
        pending_d = pending_q;
        wis_d     = wis_q;
        wb_d      = wb_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rs3_d     = rs3_q;
        data_d    = data_q;
        state_d   = ST_EMPTY;
        perf_d    = perf_q;

        // Clear first so that a set to the same bit in the same cycle wins.
        if (bus.wb_valid && bus.wb_eop) begin
            pending_d[bus.wb_wis][bus.wb_rd] = 1'b0;
        end
        if (out_fire && wb_q && (rd_q != '0)) begin
            pending_d[wis_q][rd_q] = 1'b1;
        end

        if (in_fire) begin
            wis_d  = bus.ibuf_wis;
            wb_d   = bus.ibuf_wb;
            rd_d   = bus.ibuf_rd;
            rs1_d  = bus.ibuf_rs1;
            rs2_d  = bus.ibuf_rs2;
            rs3_d  = bus.ibuf_rs3;
            data_d = bus.ibuf_data;
        end

        held_d = in_fire | ((state_q != ST_EMPTY) & ~out_fire);
        if (held_d) begin
            state_d = hazard_f(pending_d, wis_d, wb_d, rd_d, rs1_d, rs2_d, rs3_d) ? ST_STALL : ST_READY;
        end

        if ((state_q == ST_STALL) && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            pending_q <= '0;
            wis_q     <= '0;
            wb_q      <= 1'b0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
            data_q    <= '0;
            perf_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wis_q     <= wis_d;
            wb_q      <= wb_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rs3_q     <= rs3_d;
            data_q    <= data_d;
            perf_q    <= perf_d;
        end
    end
endmodule
